// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err flag.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 16000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_uart,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       irq_rx
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      sync_q, sync_d;
    logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic            fe_q, fe_d, ov_q, ov_d;
    logic            rx_s, push, fe_ev;
    logic            empty, full, do_pop, do_push, ov_ev;
`ifdef UART_RX_PARITY_EN
    logic            pe_q, pe_d, pe_ev;
`endif

    assign sync_d = {sync_q[0], rx_uart};
    assign rx_s   = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_ev   = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_ev   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d   = '0;
                    pe_ev   = rx_s != (^shift_q);
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d   = '0;
                    push    = rx_s;
                    fe_ev   = !rx_s;
                    state_d = rx_s ? S_IDLE : S_BRK;
                end
            end
            S_BRK: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = rd_en && !empty;
    assign do_push = push && (!full || do_pop);
    assign ov_ev   = push && full && !do_pop;

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = shift_q;
        wr_d = wr_q + (AW + 1)'(do_push);
        rd_d = rd_q + (AW + 1)'(do_pop);
        fe_d = (fe_q && !clr_err) || fe_ev;
        ov_d = (ov_q && !clr_err) || ov_ev;
`ifdef UART_RX_PARITY_EN
        pe_d = (pe_q && !clr_err) || pe_ev;
`endif
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            sync_q  <= 2'b11;
            wr_q    <= '0;
            rd_q    <= '0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            sync_q  <= sync_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
            pe_q    <= pe_d;
`endif
        end
    end

    assign rx_valid  = !empty;
    assign rx_data   = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
    assign frame_err = fe_q;
    assign overrun   = ov_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
    assign irq_rx     = rx_valid | fe_q | ov_q | pe_q;
`else
    assign irq_rx     = rx_valid | fe_q | ov_q;
`endif
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART 8N1 receiver with an integrated receive FIFO, sitting between the `rx_uart` pad and the vargen CPU peripheral bus.
- Consumes the serial stream the SoC's `tx_uart` produces in loopback.
- Presents received bytes first-word-fall-through to the bus read logic.
- Raises a level interrupt usable on one of the CPU `irq_*` lines.

Parameters:
- CLK_FREQ, 16000000, system clock frequency in Hz (TinyFPGA 16 MHz).
- BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated, must be >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_uart  in  1  asynchronous serial input, idle high.
- rd_en  in  1  bus pop strobe; one byte removed per cycle high while rx_valid=1.
- clr_err  in  1  one-cycle pulse; clears frame_err and overrun.
- rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- frame_err  out  1  sticky: stop bit sampled low.
- overrun  out  1  sticky: byte completed while FIFO full and not popped.
- irq_rx  out  1  rx_valid | frame_err | overrun.

Behaviour:
- Reset values:
  - FIFO empty, so rx_valid=0 and rx_data=8'h00.
  - frame_err=0, overrun=0, irq_rx=0.
  - FSM=IDLE; bit counters=0.
  - Synchronizer flops=1.
- Input sync: rx_uart passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s only.
- Baud counter:
  - Counts 0..N-1, where N is the current wait length.
  - Reloads to 0 on every state change.
- FSM:
  - IDLE: rx_s==0 -> START.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s.
    - 0 -> DATA, bit index=0.
    - 1 -> IDLE (glitch rejected, no flag).
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1 -> push the byte, then IDLE.
    - 0 -> set frame_err, discard the byte, then BRK.
  - BRK: remain until rx_s==1, then IDLE. No start detection while in BRK.
- Push latency: byte is visible on rx_data/rx_valid on the cycle after the stop-bit sample edge.
- FIFO:
  - First-word-fall-through; rx_data is driven from a registered head entry.
  - rd_en while empty: ignored, pointers unchanged.
  - Push while full, rd_en=0: byte dropped, overrun set, FIFO contents unchanged.
  - Push while full, rd_en=1 same cycle: pop and push both occur, count stays FIFO_DEPTH, no overrun.
  - Push while empty, rd_en=1 same cycle: rd_en is ignored and the byte is stored.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- Flags:
  - Sticky until clr_err.
  - If clr_err and a new error event occur in the same cycle, the flag ends set.
  - clr_err does not touch FIFO or FSM.
- Reset mid-frame: returns FSM to IDLE and empties the FIFO in the next cycle; the partial byte is lost.
  - If rx_uart is low at reset release, the line is treated as a new start edge once rx_s==0, after 2 sync cycles.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP; it samples one even-parity bit after CLKS_PER_BIT cycles.
  - A mismatch sets the additional sticky output parity_err (1 bit, reset 0, cleared by clr_err, ORed into irq_rx). The byte is still pushed.
  - Frame length is 11 bits.
- When undefined: no PARITY state, no parity_err port, 10-bit frames.

Test Plan (CLK_FREQ=16000000, BAUD=1000000, so CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Send 8'hA5 (start, 1,0,1,0,0,1,0,1, stop) -> rx_valid rises one cycle after the stop sample; rx_data=8'hA5; irq_rx=1. Pulse rd_en -> rx_valid=0, irq_rx=0.
- Send 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 back-to-back with no reads -> FIFO holds 01..04 and overrun=1. Pop 4 times -> reads 01,02,03,04, then rx_valid=0. clr_err -> overrun=0.
- Drive rx_uart low for 4 cycles, then high -> START rejects the glitch; FSM back to IDLE; no push, no flags.
- Send 8'h3C with the stop bit held low for 40 cycles -> frame_err=1, no push; FSM stays in BRK until the line goes high. Then 8'h5A -> received correctly.
- FIFO full, with rd_en asserted on the same cycle a 5th byte completes -> count stays 4, no overrun, head advances. Assert reset mid-frame -> rx_valid=0 next cycle; a subsequent 8'hC3 is received correctly.
- With UART_RX_PARITY_EN: send 8'h07 with parity bit=0 (wrong) -> byte pushed and parity_err=1. Send 8'h07 with parity bit=1 -> parity_err unchanged after clr_err stays 0.
